ram32x4_seg7_sys: RTL and testbench
===================================

// Module: ram32x4_seg7_sys
// PURPOSE
//  32-word x 4-bit synchronous RAM plus active-low 7-segment readout for DE1-SoC board-level lab use.
//  Switches drive address, write data and write enable; a pushbutton-derived clock drives clk.
//  Displays: address on HEX5/HEX4, write data on HEX2, read data on HEX0.
//  Sits directly under the board top; RAM built from flip-flops, no vendor IP.
// PARAMETERS
//  ADDR_W  5  address width; depth = 2**ADDR_W. Legal range 5..8.
// PORTS
//  clk    in   1       single clock; all state updates on rising edge
//  reset  in   1       synchronous, active-high
//  addr   in   ADDR_W  read/write address
//  din    in   4       write data
//  w      in   1       write enable, active-high
//  dout   out  4       registered read data (board top also routes it to LEDR[3:0])
//  hex5   out  7       active-low segments: addr[ADDR_W-1:4] zero-extended to 4 bits
//  hex4   out  7       active-low segments: addr[3:0]
//  hex3   out  7       unused digit (see CONFIGURATION)
//  hex2   out  7       active-low segments: din
//  hex1   out  7       unused digit (see CONFIGURATION)
//  hex0   out  7       active-low segments: dout
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high, sampled on rising clk.
//  - Reset: all memory words <= 4'h0, dout <= 4'h0; w ignored in a reset cycle; reset mid-write discards the write.
//  - Write: w=1 at rising edge -> mem[addr] <= din.
//  - Read: every rising edge, dout <= mem[addr]; one-cycle latency.
//    dout holds between edges; addr changes have no effect until the next edge.
//  - Read-during-write, same address: dout <= din (write-first / new data).
//  - w=0: memory unchanged; dout still tracks mem[addr] one cycle later.
//  - Address covers the full depth; no out-of-range case.
//  - Hex digits are purely combinational from addr, din, dout.
//    Segment bit order {g,f,e,d,c,b,a}; 0 = lit.
//  - Encoding 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex, 7-bit).
//  - HEX5 shows 0 or 1 for ADDR_W=5.
// CONFIGURATION
//  HEX_BLANK_UNUSED_EN defined   : hex3 and hex1 = 7'h7F (dark).
//  HEX_BLANK_UNUSED_EN undefined : hex3 and hex1 decode 4'hF (show "F", 7'h0E).
// STRUCTURE
//  - Package ram32x4_pkg holds:
//    - DATA_W=4 constant;
//    - typedef seg_t = logic [6:0];
//    - SEG_BLANK constant;
//    - 16-entry segment encoding table.
//  - Sub-module seg7 (val[3:0] -> seg[6:0], combinational); instantiated 6 times.
//  - Memory is an unpacked array of 2**ADDR_W words of 4 bits in one always_ff with dout.
// TESTING
//  1. Assert reset 2 cycles, addr=5'h01 -> dout=4'h0, hex0=7'h40, hex5=7'h40, hex4=7'h79.
//  2. w=1, addr=5'h01, din=4'hC, 1 edge; then w=0, 1 edge -> dout=4'hC, hex0=7'h46.
//  3. Write 4'h8 to 5'h03, then read 5'h01 -> dout=4'hC one edge after addr applied.
//     Read 5'h03 -> 4'h8; addr=5'h13 shows hex5=7'h79, hex4=7'h30.
//  4. w=1, addr=5'h1F, din=4'h5: dout=4'h5 on that same edge (write-first).
//     w=0, din=4'hA next edge -> dout stays 4'h5.
//  5. Fill all 32 words with addr[3:0]^addr[4]*4'hF, read all back -> each matches.
//     Then reset 1 cycle -> every word reads 4'h0.
//  6. Build both with and without HEX_BLANK_UNUSED_EN -> hex3/hex1 = 7'h7F / 7'h0E.

Source files
------------

// File: rtl/ram32x4_pkg.sv
// rtl/ram32x4_pkg.sv - shared constants, segment type and 0..F segment table for ram32x4_seg7_sys
package ram32x4_pkg;

   localparam int DATA_W = 4;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry 15 is the top slice, entry 0 the bottom.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/ram32x4_seg7_sys_seg7.sv
// rtl/ram32x4_seg7_sys_seg7.sv - combinational hex digit to active-low 7-segment decoder
import ram32x4_pkg::*;

module seg7 (
   input  logic [3:0] val,
   output seg_t       seg
);

   assign seg = SEG_TABLE[val];

endmodule

// File: rtl/ram32x4_seg7_sys.sv
// rtl/ram32x4_seg7_sys.sv - flip-flop RAM with write-first registered read and 7-seg readout;
// HEX_BLANK_UNUSED_EN darkens hex3/hex1, otherwise they show "F".
import ram32x4_pkg::*;

module ram32x4_seg7_sys #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              w,
   output logic [DATA_W-1:0] dout,
   output seg_t              hex5,
   output seg_t              hex4,
   output seg_t              hex3,
   output seg_t              hex2,
   output seg_t              hex1,
   output seg_t              hex0
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [3:0]        addr_hi;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         dout <= '0;
      end else if (w) begin
         // Same-address read during write returns the new data.
         mem[addr] <= din;
         dout      <= din;
      end else begin
         dout <= mem[addr];
      end
   end

   assign addr_hi = 4'(addr[ADDR_W-1:4]);

   seg7 u_hex5 (.val(addr_hi),   .seg(hex5));
   seg7 u_hex4 (.val(addr[3:0]), .seg(hex4));
   seg7 u_hex2 (.val(din),       .seg(hex2));
   seg7 u_hex0 (.val(dout),      .seg(hex0));

`ifdef HEX_BLANK_UNUSED_EN
   assign hex3 = SEG_BLANK;
   assign hex1 = SEG_BLANK;
`else
   seg7 u_hex3 (.val(4'hF), .seg(hex3));
   seg7 u_hex1 (.val(4'hF), .seg(hex1));
`endif

endmodule

// File: tb/tb_ram32x4_seg7_sys.sv
// tb/tb_ram32x4_seg7_sys.sv - scoreboard bench for ram32x4_seg7_sys (honours HEX_BLANK_UNUSED_EN)
module tb_ram32x4_seg7_sys;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] addr;
   logic [3:0] din;
   logic       w;
   logic [3:0] dout;
   logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [4:0] addr;
      logic [3:0] din;
      logic [3:0] dout;
   } exp_t;

   exp_t sb[$];

   ram32x4_seg7_sys #(.ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .addr(addr), .din(din), .w(w), .dout(dout),
      .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
         4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
         4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
         4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
      endcase
   endfunction

`ifdef HEX_BLANK_UNUSED_EN
   localparam logic [6:0] UNUSED_SEG = 7'h7F;
`else
   localparam logic [6:0] UNUSED_SEG = 7'h0E;
`endif

   task automatic check(input string n, input string f, input logic [6:0] act, input logic [6:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
      end
   endtask

   // Monitor: one expected record per clock edge, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "dout", {3'b000, dout}, {3'b000, e.dout});
            check(e.name, "hex0", hex0, enc(e.dout));
            check(e.name, "hex5", hex5, enc({3'b000, e.addr[4]}));
            check(e.name, "hex4", hex4, enc(e.addr[3:0]));
            check(e.name, "hex2", hex2, enc(e.din));
            check(e.name, "hex3", hex3, UNUSED_SEG);
            check(e.name, "hex1", hex1, UNUSED_SEG);
         end
      end
   end

   task automatic step(input string n, input logic r, input logic [4:0] a,
                       input logic [3:0] d, input logic wv, input logic [3:0] exp_dout);
      exp_t e;
      reset = r; addr = a; din = d; w = wv;
      @(posedge clk);
      e.name = n; e.addr = a; e.din = d; e.dout = exp_dout;
      sb.push_back(e);
      @(negedge clk);
   endtask

   function automatic logic [3:0] pat(input logic [4:0] a);
      pat = a[3:0] ^ (a[4] ? 4'hF : 4'h0);
   endfunction

   initial begin
      reset = 1'b1; addr = '0; din = '0; w = 1'b0;

      step("rst_a", 1'b1, 5'h01, 4'h0, 1'b1, 4'h0);
      step("rst_b", 1'b1, 5'h01, 4'h0, 1'b0, 4'h0);

      step("wr_c",   1'b0, 5'h01, 4'hC, 1'b1, 4'hC);
      step("rd_c",   1'b0, 5'h01, 4'hC, 1'b0, 4'hC);

      step("wr_8",   1'b0, 5'h03, 4'h8, 1'b1, 4'h8);
      step("rd_01",  1'b0, 5'h01, 4'h8, 1'b0, 4'hC);
      step("rd_03",  1'b0, 5'h03, 4'h8, 1'b0, 4'h8);
      step("rd_13",  1'b0, 5'h13, 4'h8, 1'b0, 4'h0);

      step("wf_1f",  1'b0, 5'h1F, 4'h5, 1'b1, 4'h5);
      step("hold",   1'b0, 5'h1F, 4'hA, 1'b0, 4'h5);

      for (int i = 0; i < 32; i++) step("fill", 1'b0, 5'(i), pat(5'(i)), 1'b1, pat(5'(i)));
      for (int i = 0; i < 32; i++) step("read", 1'b0, 5'(i), 4'h3, 1'b0, pat(5'(i)));

      step("rst_wr", 1'b1, 5'h07, 4'h9, 1'b1, 4'h0);
      for (int i = 0; i < 32; i++) step("clear", 1'b0, 5'(i), 4'h0, 1'b0, 4'h0);

      repeat (2) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
